// File: rtl/wb_pipe_master.sv
// ---------------------------------------------------------------------------
// wb_pipe_master
//
// Wishbone B4 pipelined bus initiator. Turns a valid/ready request stream
// into pipelined STB/STALL/ACK bus transactions, keeps several transactions
// in flight, and returns one response per accepted request in request
// order. A watchdog aborts the bus cycle when the slave stops making
// progress, completing every pending request with an error response.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake (accept on valid & ready)
//   req_write           1 = write, 0 = read
//   req_addr            word address
//   req_wdata           write data
//   req_byteenable      byte selects
//   rsp_valid           one-cycle response pulse, in request order
//   rsp_write           response belongs to a write
//   rsp_err             response produced by a timeout abort
//   rsp_rdata           read data (0 for writes and errors)
//   wb_*_o / wb_*_i     Wishbone B4 pipelined master interface
// ---------------------------------------------------------------------------
module wb_pipe_master #(
    parameter int AW              = 24,
    parameter int DW              = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_byteenable,
    output logic            rsp_valid,
    output logic            rsp_write,
    output logic            rsp_err,
    output logic [DW-1:0]   rsp_rdata,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_stall_i
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT
    } FsmState;

    FsmState                r_state;
    FsmState                w_nextState;

    logic [MAX_OUTSTANDING-1:0] r_typeFifo;
    logic [PW-1:0]          r_wrPtr;
    logic [PW-1:0]          r_rdPtr;
    logic [CW-1:0]          r_fifoCount;
    logic [CW-1:0]          r_outCnt;
    logic [TW-1:0]          r_tmoCnt;

    logic                   r_stb;
    logic                   r_we;
    logic [AW-1:0]          r_adr;
    logic [DW-1:0]          r_dat;
    logic [DW/8-1:0]        r_sel;

    logic                   r_rspValid;
    logic                   r_rspWrite;
    logic                   r_rspErr;
    logic [DW-1:0]          r_rspRdata;

    logic                   w_accept;
    logic                   w_issue;
    logic                   w_validAck;
    logic                   w_abortPop;
    logic                   w_pop;
    logic                   w_fifoEmpty;
    logic                   w_fifoFull;
    logic                   w_fifoHead;
    logic [CW-1:0]          w_countNext;
    logic                   w_tmoExpired;
    logic                   w_enterAbort;

    // The FIFO occupancy covers both the request waiting in the issue
    // register and everything already on the bus, so "full" throttles the
    // request side to MAX_OUTSTANDING in total. req_ready only looks at
    // registered state plus stall, never at ack.
    assign w_fifoEmpty  = (r_fifoCount == '0);
    assign w_fifoFull   = (r_fifoCount == CW'(MAX_OUTSTANDING));
    assign w_fifoHead   = r_typeFifo[r_rdPtr];
    assign req_ready    = rst_n & (r_state != ABORT) & ~w_fifoFull & (~r_stb | ~wb_stall_i);
    assign w_accept     = req_valid & req_ready;
    assign w_issue      = r_stb & ~wb_stall_i;
    // An ack with nothing already issued is spurious, which also means an
    // ack can never complete the transaction being issued this same cycle.
    assign w_validAck   = wb_ack_i & (r_outCnt != '0) & (r_state == ACTIVE);
    assign w_abortPop   = (r_state == ABORT) & ~w_fifoEmpty;
    assign w_pop        = w_validAck | w_abortPop;
    assign w_countNext  = r_fifoCount + CW'(w_accept) - CW'(w_pop);
    assign w_tmoExpired = (r_tmoCnt == TW'(TIMEOUT - 1)) & ~w_fifoEmpty & ~w_issue & ~w_validAck;
    assign w_enterAbort = (r_state == ACTIVE) & (w_nextState == ABORT);

    assign wb_cyc_o  = r_stb | (r_outCnt != '0);
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign rsp_valid = r_rspValid;
    assign rsp_write = r_rspWrite;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rspRdata;

    // State register for the bus-cycle controller.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. ACTIVE and ABORT both fall back to IDLE once the
    // type FIFO drains; ACTIVE escapes to ABORT when the watchdog expires.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_countNext == '0) begin
                    w_nextState = IDLE;
                end else if (w_tmoExpired) begin
                    w_nextState = ABORT;
                end
            end
            ABORT: begin
                if (w_countNext == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Type FIFO holding the we bit of every accepted request, so responses
    // can be tagged read/write in order even when the bus cycle is aborted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_typeFifo  <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
        end else begin
            if (w_accept) begin
                r_typeFifo[r_wrPtr] <= req_write;
                r_wrPtr             <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_fifoCount <= w_countNext;
        end
    end

    // Issue register. A new request may be loaded whenever the current one
    // issues (or none is pending), which gives back-to-back strobes; while
    // stalled everything is held. An abort wipes the pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_enterAbort) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_accept) begin
            r_stb <= 1'b1;
            r_we  <= req_write;
            r_adr <= req_addr;
            r_dat <= req_wdata;
            r_sel <= req_byteenable;
        end else if (w_issue) begin
            r_stb <= 1'b0;
        end
    end

    // Count of transactions issued on the bus but not yet acknowledged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outCnt <= '0;
        end else if (w_enterAbort) begin
            r_outCnt <= '0;
        end else begin
            r_outCnt <= r_outCnt + CW'(w_issue) - CW'(w_validAck);
        end
    end

    // Watchdog: counts consecutive cycles with work pending but neither an
    // issue nor an ack, covering both an endless stall and a lost ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmoCnt <= '0;
        end else if ((r_state != ACTIVE) || w_issue || w_validAck || w_fifoEmpty) begin
            r_tmoCnt <= '0;
        end else begin
            r_tmoCnt <= r_tmoCnt + TW'(1);
        end
    end

    // Registered response stage: one cycle after a valid ack, or one per
    // popped entry while flushing the FIFO with error responses in ABORT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else if (w_abortPop) begin
            r_rspValid <= 1'b1;
            r_rspWrite <= w_fifoHead;
            r_rspErr   <= 1'b1;
            r_rspRdata <= '0;
        end else if (w_validAck) begin
            r_rspValid <= 1'b1;
            r_rspWrite <= w_fifoHead;
            r_rspErr   <= 1'b0;
            r_rspRdata <= w_fifoHead ? '0 : wb_dat_i;
        end else begin
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end
    end

endmodule

// File: tb/tb_wb_pipe_master.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_master
//
// Directed testbench for wb_pipe_master (TIMEOUT shortened to 16). The bench
// plays the Wishbone slave cycle by cycle and compares the DUT outputs with
// hand-computed expectations: single write, back-to-back reads, stall and
// FIFO-full throttling, spurious acks, watchdog abort, and mid-cycle reset.
// ---------------------------------------------------------------------------
module tb_wb_pipe_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_byteenable;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [23:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;

    int testsRun;
    int testsFailed;

    wb_pipe_master #(
        .AW(24),
        .DW(16),
        .MAX_OUTSTANDING(4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_byteenable(req_byteenable),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_stall_i(wb_stall_i)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the sequence wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected sequence end");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    // Compares one observed value with its expected value and logs a miss.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives the request side and the slave side for the current cycle, then
    // lets combinational outputs settle before any check.
    task automatic applyStimulus(input logic v, input logic w, input logic [23:0] a,
                                 input logic [15:0] d, input logic [1:0] be,
                                 input logic ack, input logic [15:0] dat, input logic stall);
        req_valid      = v;
        req_write      = w;
        req_addr       = a;
        req_wdata      = d;
        req_byteenable = be;
        wb_ack_i       = ack;
        wb_dat_i       = dat;
        wb_stall_i     = stall;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
    endtask

    // Advance to just after the next rising edge so registers have settled.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_byteenable = '0; wb_ack_i = 1'b0; wb_dat_i = '0; wb_stall_i = 1'b0;

        // ---------------- reset state ----------------
        nextCycle();
        nextCycle();
        applyIdle();
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_cyc", wb_cyc_o, 0);
        checkOutput("rst_stb", wb_stb_o, 0);
        checkOutput("rst_rspv", rsp_valid, 0);
        checkOutput("rst_adr", wb_adr_o, 0);
        rst_n = 1'b1;
        nextCycle();
        applyIdle();
        checkOutput("post_rst_ready", req_ready, 1);
        nextCycle();

        // ---------------- single write ----------------
        $display("[TB] single write");
        applyStimulus(1'b1, 1'b1, 24'h000010, 16'hBEEF, 2'b11, 1'b0, 16'h0, 1'b0);
        checkOutput("wr_ready", req_ready, 1);
        checkOutput("wr_cyc0", wb_cyc_o, 0);
        nextCycle();
        applyIdle();
        checkOutput("wr_stb", wb_stb_o, 1);
        checkOutput("wr_we", wb_we_o, 1);
        checkOutput("wr_adr", wb_adr_o, 32'h10);
        checkOutput("wr_dat", wb_dat_o, 32'hBEEF);
        checkOutput("wr_sel", wb_sel_o, 32'h3);
        checkOutput("wr_cyc1", wb_cyc_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'h0, 1'b0);
        checkOutput("wr_stb_drop", wb_stb_o, 0);
        checkOutput("wr_cyc2", wb_cyc_o, 1);
        checkOutput("wr_rspv_early", rsp_valid, 0);
        nextCycle();
        applyIdle();
        checkOutput("wr_rspv", rsp_valid, 1);
        checkOutput("wr_rspw", rsp_write, 1);
        checkOutput("wr_rsperr", rsp_err, 0);
        checkOutput("wr_rdata", rsp_rdata, 0);
        checkOutput("wr_cyc_end", wb_cyc_o, 0);
        nextCycle();
        applyIdle();
        checkOutput("wr_rspv_end", rsp_valid, 0);
        nextCycle();

        // ---------------- 4 back-to-back reads, ack latency 2 ----------------
        $display("[TB] back-to-back reads");
        for (int c = 0; c < 9; c++) begin
            applyStimulus(c < 4, 1'b0, 24'(c), 16'h0, 2'b11,
                          (c >= 3 && c <= 6), 16'(32'h1000 + c - 3), 1'b0);
            checkOutput("b2b_stb", wb_stb_o, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) checkOutput("b2b_adr", wb_adr_o, c - 1);
            if (c < 4) checkOutput("b2b_ready", req_ready, 1);
            checkOutput("b2b_cyc", wb_cyc_o, (c >= 1 && c <= 6));
            checkOutput("b2b_rspv", rsp_valid, (c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) begin
                checkOutput("b2b_rdata", rsp_rdata, 32'h1000 + c - 4);
                checkOutput("b2b_rspw", rsp_write, 0);
            end
            nextCycle();
        end

        // ---------------- stall hold, then FIFO-full throttling ----------------
        $display("[TB] stall and fifo full");
        for (int c = 0; c < 17; c++) begin
            logic        v;
            logic [23:0] a;
            logic        ack;
            logic [15:0] dat;
            v   = (c == 0) || (c >= 6 && c <= 11);
            a   = (c == 0) ? 24'h55 : ((c <= 8) ? 24'(32'h50 + c) : 24'h99);
            ack = (c >= 11 && c <= 14);
            dat = (c == 11) ? 16'hAA55 : 16'(32'hB000 + c - 11);
            applyStimulus(v, 1'b0, a, 16'h0, 2'b01, ack, dat, (c >= 1 && c <= 5));
            if (c >= 1 && c <= 6) begin
                checkOutput("stall_stb", wb_stb_o, 1);
                checkOutput("stall_adr", wb_adr_o, 32'h55);
                checkOutput("stall_ready", req_ready, (c == 6));
            end
            if (c >= 7 && c <= 9) begin
                checkOutput("pipe_stb", wb_stb_o, 1);
                checkOutput("pipe_adr", wb_adr_o, 32'h50 + c - 1);
            end
            if (c >= 9 && c <= 11) checkOutput("full_ready", req_ready, 0);
            if (c == 10) checkOutput("full_stb", wb_stb_o, 0);
            if (c == 12) checkOutput("unfull_ready", req_ready, 1);
            checkOutput("stall_rspv", rsp_valid, (c >= 12 && c <= 15));
            if (c == 12) checkOutput("stall_rdata0", rsp_rdata, 32'hAA55);
            if (c >= 13 && c <= 15) checkOutput("stall_rdata", rsp_rdata, 32'hB000 + c - 12);
            checkOutput("stall_cyc", wb_cyc_o, (c >= 1 && c <= 14));
            nextCycle();
        end

        // ---------------- spurious acks ----------------
        $display("[TB] spurious acks");
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'hFFFF, 1'b0);
        checkOutput("sp_cyc0", wb_cyc_o, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 24'h77, 16'h0, 2'b11, 1'b0, 16'h0, 1'b0);
        checkOutput("sp_idle_rspv", rsp_valid, 0);
        checkOutput("sp_idle_cyc", wb_cyc_o, 0);
        checkOutput("sp_ready", req_ready, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'hDEAD, 1'b0);
        checkOutput("sp_stb", wb_stb_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'h1234, 1'b0);
        checkOutput("sp_sameissue_rspv", rsp_valid, 0);
        checkOutput("sp_cyc_held", wb_cyc_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'h5555, 1'b0);
        checkOutput("sp_rspv", rsp_valid, 1);
        checkOutput("sp_rdata", rsp_rdata, 32'h1234);
        checkOutput("sp_rspw", rsp_write, 0);
        checkOutput("sp_cyc_end", wb_cyc_o, 0);
        nextCycle();
        applyIdle();
        checkOutput("sp_extra_rspv", rsp_valid, 0);
        checkOutput("sp_extra_cyc", wb_cyc_o, 0);
        nextCycle();

        // ---------------- watchdog abort ----------------
        $display("[TB] timeout abort");
        for (int c = 0; c < 25; c++) begin
            applyStimulus(c < 3, 1'b0, 24'(32'h20 + c), 16'h0, 2'b11, 1'b0, 16'hCAFE, 1'b0);
            checkOutput("tmo_cyc", wb_cyc_o, (c >= 1 && c <= 19));
            checkOutput("tmo_stb", wb_stb_o, (c >= 1 && c <= 3));
            checkOutput("tmo_ready", req_ready, (c <= 19 || c >= 23));
            checkOutput("tmo_rspv", rsp_valid, (c >= 21 && c <= 23));
            if (c >= 21 && c <= 23) begin
                checkOutput("tmo_err", rsp_err, 1);
                checkOutput("tmo_rdata", rsp_rdata, 0);
                checkOutput("tmo_rspw", rsp_write, 0);
            end
            nextCycle();
        end

        // ---------------- reset with transactions in flight ----------------
        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 1'b0, 24'h30, 16'h0, 2'b11, 1'b0, 16'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 24'h31, 16'h0, 2'b11, 1'b0, 16'h0, 1'b0);
        nextCycle();
        applyIdle();
        nextCycle();
        applyIdle();
        checkOutput("mr_cyc_before", wb_cyc_o, 1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'hFFFF, 1'b0);
        checkOutput("mr_ready_in_rst", req_ready, 0);
        nextCycle();
        rst_n = 1'b1;
        applyIdle();
        checkOutput("mr_cyc", wb_cyc_o, 0);
        checkOutput("mr_stb", wb_stb_o, 0);
        checkOutput("mr_we", wb_we_o, 0);
        checkOutput("mr_adr", wb_adr_o, 0);
        checkOutput("mr_dat", wb_dat_o, 0);
        checkOutput("mr_sel", wb_sel_o, 0);
        checkOutput("mr_rspv", rsp_valid, 0);
        checkOutput("mr_rsperr", rsp_err, 0);
        checkOutput("mr_rspw", rsp_write, 0);
        checkOutput("mr_rdata", rsp_rdata, 0);
        checkOutput("mr_ready", req_ready, 1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 24'h40, 16'h0, 2'b11, 1'b0, 16'h0, 1'b0);
        checkOutput("mr_rspv2", rsp_valid, 0);
        nextCycle();
        applyIdle();
        checkOutput("mr_new_stb", wb_stb_o, 1);
        checkOutput("mr_new_adr", wb_adr_o, 32'h40);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b1, 16'h4444, 1'b0);
        checkOutput("mr_new_cyc", wb_cyc_o, 1);
        checkOutput("mr_new_rspv0", rsp_valid, 0);
        nextCycle();
        applyIdle();
        checkOutput("mr_new_rspv", rsp_valid, 1);
        checkOutput("mr_new_rdata", rsp_rdata, 32'h4444);
        checkOutput("mr_new_err", rsp_err, 0);
        nextCycle();
        applyIdle();
        checkOutput("mr_new_cyc_end", wb_cyc_o, 0);
        checkOutput("mr_new_rspv_end", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
